sram_request_sequencer: RTL and testbench

//  Converts single-word read/write requests (valid/ready) from the Hack CPU/memory-map side into

---
 rtl/sram_request_sequencer_pkg.sv | 29 ++
 rtl/sram_request_sequencer_if.sv | 29 ++
 rtl/sram_request_sequencer_dq_iobuf.sv | 39 +++
 rtl/sram_request_sequencer.sv | 159 +++++++++++++++
 tb/tb_sram_request_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_request_sequencer_pkg.sv
// Shared types and defaults for the async-SRAM request sequencer: FSM states,
// counter type and timing defaults.
package sram_request_sequencer_pkg;

    localparam int DEF_ADDR_W     = 18;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;

    localparam int CNT_W   = 4;
    localparam int MAX_CYC = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // The down-counter is loaded with cycles-1 so that a value of 0 marks
    // the final cycle of a phase.
    function automatic cnt_t load_count(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_request_sequencer_if.sv
// Request/response handshake between the CPU/memory-map side (master) and
// the SRAM sequencer (slave).
interface sram_request_sequencer_if
    import sram_request_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/sram_request_sequencer_dq_iobuf.sv
// SRAM DQ pad logic: registered output enable and output data driving a
// tri-state bus, plus the read-data sample register.
module sram_request_sequencer_dq_iobuf
    import sram_request_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe_d,
    input  logic [DATA_W-1:0] dout_d,
    input  logic              sample_en,
    output logic [DATA_W-1:0] rdata_q,
    inout  wire  [DATA_W-1:0] dq
);

    logic              oe_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata_d;

    assign rdata_d = sample_en ? dq : rdata_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q    <= 1'b0;
            dout_q  <= '0;
            rdata_q <= '0;
        end else begin
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
        end
    end

    assign dq = oe_q ? dout_q : 'z;

endmodule

// File: rtl/sram_request_sequencer.sv
// Turns single-word valid/ready requests into async-SRAM cycles
// (setup, strobe, hold) with registered, contention-free pin timing.
module sram_request_sequencer
    import sram_request_sequencer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_request_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]       sram_addr,
    inout  wire  [DATA_W-1:0]       sram_dq,
    output logic                    sram_csx,
    output logic                    sram_oex,
    output logic                    sram_wex
);

    if (STROBE_CYC < 1 || STROBE_CYC > MAX_CYC ||
        SETUP_CYC < 0 || SETUP_CYC > MAX_CYC ||
        HOLD_CYC < 0 || HOLD_CYC > MAX_CYC) begin : g_bad_timing
        $error("sram_request_sequencer: timing parameters out of range");
    end

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              csx_q, csx_d;
    logic              oex_q, oex_d;
    logic              wex_q, wex_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              dq_oe_d;
    logic              sample_en;
    logic              accept;

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        sample_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (SETUP_CYC != 0) begin
                        state_d = ST_SETUP;
                        cnt_d   = load_count(SETUP_CYC);
                    end else begin
                        state_d = ST_STROBE;
                        cnt_d   = load_count(STROBE_CYC);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = load_count(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    sample_en = !write_q;
                    if (HOLD_CYC != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = load_count(HOLD_CYC);
                    end else begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins are decoded from the next state so they switch on the same
        // edge as the FSM and stay glitch-free as flop outputs.
        csx_d   = (state_d == ST_IDLE);
        oex_d   = !((state_d == ST_STROBE) && !write_d);
        wex_d   = !((state_d == ST_STROBE) && write_d);
        dq_oe_d = write_d && ((state_d == ST_STROBE) || (state_d == ST_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            csx_q       <= 1'b1;
            oex_q       <= 1'b1;
            wex_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            csx_q       <= csx_d;
            oex_q       <= oex_d;
            wex_q       <= wex_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    sram_request_sequencer_dq_iobuf #(
        .DATA_W (DATA_W)
    ) u_iobuf (
        .clk       (clk),
        .rst       (rst),
        .oe_d      (dq_oe_d),
        .dout_d    (wdata_d),
        .sample_en (sample_en),
        .rdata_q   (bus.rsp_rdata),
        .dq        (sram_dq)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign sram_addr     = addr_q;
    assign sram_csx      = csx_q;
    assign sram_oex      = oex_q;
    assign sram_wex      = wex_q;

endmodule

// File: tb/tb_sram_request_sequencer.sv
// Randomized self-checking bench for sram_request_sequencer against a
// transaction-level timing model and a behavioural async-SRAM.
module tb_sram_request_sequencer;
    import sram_request_sequencer_pkg::*;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;
    localparam int P = S + T + H;
    localparam logic [DATA_W-1:0] MEM_INIT = 16'h0C3A;
    localparam logic [DATA_W-1:0] FLOAT    = 16'hFFFF;
    localparam logic [DATA_W-1:0] DUT2_RD  = 16'h5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (default timing) ----------------
    logic              rst;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_dq;
    logic              sram_csx, sram_oex, sram_wex;

    sram_request_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    sram_request_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)
    ) dut (
        .clk(clk), .rst(rst), .bus(bif),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_csx(sram_csx), .sram_oex(sram_oex), .sram_wex(sram_wex)
    );

    // Behavioural async SRAM: drives while selected with OEX low, writes while WEX low.
    pullup (sram_dq);
    logic [DATA_W-1:0] mem [1024] = '{default: MEM_INIT};
    assign sram_dq = (!sram_csx && !sram_oex) ? mem[sram_addr[9:0]] : 'z;
    always @(negedge clk) begin
        if (!sram_csx && !sram_wex) mem[sram_addr[9:0]] <= sram_dq;
    end

    // ---------------- second DUT (SETUP=0, STROBE=1, HOLD=0) ----------------
    logic              rst2;
    logic [ADDR_W-1:0] sram_addr2;
    wire  [DATA_W-1:0] sram_dq2;
    logic              sram_csx2, sram_oex2, sram_wex2;

    sram_request_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif2 ();

    sram_request_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)
    ) dut2 (
        .clk(clk), .rst(rst2), .bus(bif2),
        .sram_addr(sram_addr2), .sram_dq(sram_dq2),
        .sram_csx(sram_csx2), .sram_oex(sram_oex2), .sram_wex(sram_wex2)
    );

    pullup (sram_dq2);
    assign sram_dq2 = (!sram_csx2 && !sram_oex2) ? DUT2_RD : 'z;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    // t counts clock edges since the accept edge: 1..S setup, then T strobe, then H hold.
    bit                busy_m, rsp_pend, cur_write;
    int                t;
    logic [ADDR_W-1:0] addr_m;
    logic [DATA_W-1:0] cur_wdata, cur_rdata, rdata_m;
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    int                dut_rsp_cnt;

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return MEM_INIT;
    endfunction

    task automatic model_step();
        if (rst) begin
            busy_m = 0; rsp_pend = 0; t = 0; addr_m = '0; rdata_m = '0;
        end else begin
            rsp_pend = 0;
            if (busy_m) begin
                if (t == S + T && !cur_write) rdata_m = cur_rdata;
                if (t == P) begin
                    busy_m   = 0;
                    rsp_pend = 1;
                end else begin
                    t++;
                end
            end else if (bif.req_valid) begin
                busy_m    = 1;
                t         = 1;
                cur_write = bif.req_write;
                addr_m    = bif.req_addr;
                cur_wdata = bif.req_wdata;
                if (cur_write) ref_mem[addr_m] = cur_wdata;
                else cur_rdata = ref_read(addr_m);
            end
        end
    endtask

    task automatic check_outputs();
        bit strobe, hold;
        strobe = busy_m && t > S && t <= S + T;
        hold   = busy_m && t > S + T;
        check("req_ready", bif.req_ready, !busy_m && !rst);
        check("busy", bif.busy, busy_m);
        check("csx", sram_csx, !busy_m);
        check("oex", sram_oex, !(strobe && !cur_write));
        check("wex", sram_wex, !(strobe && cur_write));
        check("sram_addr", sram_addr, addr_m);
        if (busy_m && cur_write && (strobe || hold)) check("dq_write", sram_dq, cur_wdata);
        else if (strobe && !cur_write) check("dq_read", sram_dq, cur_rdata);
        else check("dq_float", sram_dq, FLOAT);
        check("rsp_valid", bif.rsp_valid, rsp_pend);
        check("rsp_rdata", bif.rsp_rdata, rdata_m);
        if (bif.rsp_valid) dut_rsp_cnt++;
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    // Random request fields with valid low: these must be ignored.
    task automatic noise();
        bif.req_valid = 1'b0;
        bif.req_write = 1'($urandom_range(0, 1));
        bif.req_addr  = ADDR_W'($urandom);
        bif.req_wdata = DATA_W'($urandom);
    endtask

    task automatic set_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = a;
        bif.req_wdata = d;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return {8'hAA, 6'b111100, 4'($urandom_range(0, 15))};
    endfunction

    task automatic wait_idle();
        int n = 0;
        noise();
        while (busy_m && n < 20) begin
            run_cycle();
            noise();
            n++;
        end
        if (busy_m) check("wait_idle_timeout", 1, 0);
        run_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bif2.req_valid = 1'b0; bif2.req_write = 1'b0;
        bif2.req_addr  = '0;   bif2.req_wdata = '0;
        dut_rsp_cnt = 0;
        noise();
        repeat (2) run_cycle();
        rst = 1'b0;
        run_cycle();

        // Directed write then read of 0x2ABCD with request fields toggling while busy.
        set_req(1'b1, 18'h2ABCD, 16'h1234);
        run_cycle();
        wait_idle();
        check("mem_2abcd", mem[10'h3CD], 16'h1234);
        set_req(1'b0, 18'h2ABCD, 16'h0000);
        run_cycle();
        wait_idle();
        check("rd_2abcd", bif.rsp_rdata, 16'h1234);

        // Back-to-back read, write, read with valid held high: three responses.
        dut_rsp_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 15) set_req(k >= 5 && k < 10, rand_addr(), DATA_W'($urandom_range(0, 16'hFFFE)));
            else noise();
            run_cycle();
        end
        check("b2b_rsp_count", dut_rsp_cnt, 3);
        wait_idle();

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) != 0)
                set_req(1'($urandom_range(0, 1)), rand_addr(), DATA_W'($urandom_range(0, 16'hFFFE)));
            else noise();
            run_cycle();
        end
        wait_idle();

        // Reset during the write strobe: abort, no response, no retry.
        set_req(1'b1, rand_addr(), 16'hBEEF);
        run_cycle();
        noise();
        for (int n = 0; n < 10 && !(busy_m && t == S + 1); n++) run_cycle();
        check("wex_before_rst", sram_wex, 0);
        rst = 1'b1;
        bif.req_valid = 1'b1;
        #1;
        check("ready_in_rst", bif.req_ready, 0);
        repeat (3) run_cycle();
        rst = 1'b0;
        noise();
        dut_rsp_cnt = 0;
        repeat (8) run_cycle();
        check("no_rsp_after_abort", dut_rsp_cnt, 0);

        // Minimal-timing instance: read accepted at edge 0, strobe cyc1, response cyc2.
        rst2 = 1'b0;
        @(posedge clk); @(negedge clk);
        bif2.req_valid = 1'b1; bif2.req_write = 1'b0; bif2.req_addr = 18'h00123;
        #1;
        check("d2_ready", bif2.req_ready, 1);
        @(posedge clk); @(negedge clk);
        bif2.req_valid = 1'b0; bif2.req_addr = 18'h3FFFF;
        check("d2_c1_oex", sram_oex2, 0);
        check("d2_c1_csx", sram_csx2, 0);
        check("d2_c1_wex", sram_wex2, 1);
        check("d2_c1_addr", sram_addr2, 18'h00123);
        check("d2_c1_dq", sram_dq2, DUT2_RD);
        check("d2_c1_rsp", bif2.rsp_valid, 0);
        check("d2_c1_busy", bif2.busy, 1);
        @(posedge clk); @(negedge clk);
        check("d2_c2_oex", sram_oex2, 1);
        check("d2_c2_csx", sram_csx2, 1);
        check("d2_c2_rsp", bif2.rsp_valid, 1);
        check("d2_c2_rdata", bif2.rsp_rdata, DUT2_RD);
        check("d2_c2_ready", bif2.req_ready, 1);
        check("d2_c2_dq", sram_dq2, FLOAT);
        @(posedge clk); @(negedge clk);
        check("d2_c3_rsp", bif2.rsp_valid, 0);
        check("d2_c3_addr", sram_addr2, 18'h00123);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
